// File: rtl/axbtb_write_scheduler.sv
// Write scheduler for the banked approximate-BCC buffer RAM.
// Sweeps every entry invalid after reset and on flush. In RUN it arbitrates
// the RAM write ports between the deferral queue head and this cycle's update
// requests, so that no two grants in one cycle hit the same bank.
module axbtb_write_scheduler #(
    parameter int ENTRY_NUM  = 512,
    parameter int BANK_NUM   = 2,
    parameter int WRITE_NUM  = 2,
    parameter int QUEUE_SIZE = 4,
    parameter int TAG_WIDTH  = 10,
    parameter int IDX_W      = $clog2(ENTRY_NUM),
    localparam int CNT_W     = $clog2(QUEUE_SIZE + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flushReq,
    input  logic [WRITE_NUM-1:0]           reqValid,
    input  logic [WRITE_NUM*IDX_W-1:0]     reqIndex,
    input  logic [WRITE_NUM*TAG_WIDTH-1:0] reqTag,
    output logic [WRITE_NUM-1:0]           ramWE,
    output logic [WRITE_NUM*IDX_W-1:0]     ramWA,
    output logic [WRITE_NUM*TAG_WIDTH-1:0] ramWTag,
    output logic [WRITE_NUM-1:0]           ramWValid,
    output logic                           readBlock,
    output logic                           busy,
    output logic [CNT_W-1:0]               queueCount,
    output logic [15:0]                    dropCount
);

    localparam int PTR_W = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;

    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     sweep_idx;

    logic [IDX_W-1:0]     q_idx [QUEUE_SIZE];
    logic [TAG_WIDTH-1:0] q_tag [QUEUE_SIZE];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic                 pop;
    logic [WRITE_NUM-1:0] push_en;
    logic [PTR_W-1:0]     push_slot [WRITE_NUM];
    logic [WRITE_NUM-1:0] req_granted;
    logic [BANK_NUM-1:0]  bank_used;
    int unsigned          push_total;
    int unsigned          drop_total;
    int unsigned          ports;
    int unsigned          bank;
    int unsigned          free;

    logic [PTR_W-1:0]     head_next;
    logic [PTR_W-1:0]     tail_next;
    logic [CNT_W-1:0]     count_next;
    logic [16:0]          drop_sum;

    function automatic int unsigned bank_of(input logic [IDX_W-1:0] idx);
        return int'(32'(idx)) % BANK_NUM;
    endfunction

    // State register and sweep counter; the sweep index rests at 0 in RUN so a flush starts there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_next;
            sweep_idx <= (state != RUN) ? sweep_idx + 1'b1 : '0;
        end
    end

    // Next-state: a sweep ends after its last entry, a flush request leaves RUN.
    always_comb begin
        state_next = state;
        case (state)
            INIT, FLUSH: if (sweep_idx == IDX_W'(ENTRY_NUM - 1)) state_next = RUN;
            RUN:         if (flushReq) state_next = FLUSH;
            default:     state_next = INIT;
        endcase
    end

    // Port arbitration: queue head first, then requesters in order; one grant per bank per cycle.
    always_comb begin
        ramWE       = '0;
        ramWA       = '0;
        ramWTag     = '0;
        ramWValid   = '0;
        pop         = 1'b0;
        push_en     = '0;
        req_granted = '0;
        bank_used   = '0;
        push_total  = 0;
        drop_total  = 0;
        ports       = 0;
        bank        = 0;
        free        = 0;
        for (int unsigned i = 0; i < WRITE_NUM; i++) push_slot[i] = '0;
        if (!rst) begin
            if (state != RUN) begin
                ramWE[0]          = 1'b1;
                ramWA[IDX_W-1:0]  = sweep_idx;
            end else begin
                if (count != '0) begin
                    bank                     = bank_of(q_idx[head]);
                    ramWE[0]                 = 1'b1;
                    ramWA[IDX_W-1:0]         = q_idx[head];
                    ramWTag[TAG_WIDTH-1:0]   = q_tag[head];
                    ramWValid[0]             = 1'b1;
                    bank_used[bank]          = 1'b1;
                    ports                    = 1;
                    pop                      = 1'b1;
                end
                for (int unsigned i = 0; i < WRITE_NUM; i++) begin
                    if (reqValid[i]) begin
                        bank = bank_of(reqIndex[i*IDX_W +: IDX_W]);
                        if (ports < WRITE_NUM && !bank_used[bank]) begin
                            ramWE[ports]                          = 1'b1;
                            ramWA[ports*IDX_W +: IDX_W]           = reqIndex[i*IDX_W +: IDX_W];
                            ramWTag[ports*TAG_WIDTH +: TAG_WIDTH] = reqTag[i*TAG_WIDTH +: TAG_WIDTH];
                            ramWValid[ports]                      = 1'b1;
                            bank_used[bank]                       = 1'b1;
                            req_granted[i]                        = 1'b1;
                            ports                                 = ports + 1;
                        end
                    end
                end
                // A flush discards the queue, so deferring anything this cycle is pointless.
                if (!flushReq) begin
                    free = QUEUE_SIZE - int'(count) + (pop ? 1 : 0);
                    for (int unsigned i = 0; i < WRITE_NUM; i++) begin
                        if (reqValid[i] && !req_granted[i]) begin
                            if (push_total < free) begin
                                push_en[i]   = 1'b1;
                                push_slot[i] = PTR_W'((int'(tail) + push_total) % QUEUE_SIZE);
                                push_total   = push_total + 1;
                            end else begin
                                drop_total   = drop_total + 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Queue pointer, occupancy and drop-counter updates.
    always_comb begin
        head_next  = (int'(head) == QUEUE_SIZE - 1) ? '0 : head + 1'b1;
        tail_next  = PTR_W'((int'(tail) + push_total) % QUEUE_SIZE);
        count_next = CNT_W'(int'(count) - (pop ? 1 : 0) + push_total);
        drop_sum   = {1'b0, dropCount} + 17'(drop_total);
    end

    // Queue control and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dropCount <= '0;
        end else if (state == RUN) begin
            if (flushReq) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop) head <= head_next;
                tail  <= tail_next;
                count <= count_next;
            end
            dropCount <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // Deferred entry storage; occupancy is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WRITE_NUM; i++) begin
            if (push_en[i]) begin
                q_idx[push_slot[i]] <= reqIndex[i*IDX_W +: IDX_W];
                q_tag[push_slot[i]] <= reqTag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // Status outputs.
    always_comb begin
        readBlock  = rst || (state != RUN);
        busy       = readBlock || (count != '0);
        queueCount = count;
    end

endmodule

// File: tb/tb_axbtb_write_scheduler.sv
// Directed self-checking bench for axbtb_write_scheduler (default parameters).
module tb_axbtb_write_scheduler;

    logic        clk;
    logic        rst;
    logic        flushReq;
    logic [1:0]  reqValid;
    logic [17:0] reqIndex;
    logic [19:0] reqTag;
    logic [1:0]  ramWE;
    logic [17:0] ramWA;
    logic [19:0] ramWTag;
    logic [1:0]  ramWValid;
    logic        readBlock;
    logic        busy;
    logic [2:0]  queueCount;
    logic [15:0] dropCount;

    int checks = 0;
    int errors = 0;

    axbtb_write_scheduler #(
        .ENTRY_NUM(512), .BANK_NUM(2), .WRITE_NUM(2), .QUEUE_SIZE(4), .TAG_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .flushReq(flushReq),
        .reqValid(reqValid), .reqIndex(reqIndex), .reqTag(reqTag),
        .ramWE(ramWE), .ramWA(ramWA), .ramWTag(ramWTag), .ramWValid(ramWValid),
        .readBlock(readBlock), .busy(busy), .queueCount(queueCount), .dropCount(dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tag of every request is its index + 0x100.
    task automatic set_req(input logic [1:0] v, input int i0, input int i1);
        reqValid = v;
        reqIndex = {9'(i1), 9'(i0)};
        reqTag   = {10'(i1 + 256), 10'(i0 + 256)};
    endtask

    task automatic test_reset();
        rst = 1'b1; flushReq = 1'b0;
        set_req(2'b11, 1, 2);
        step();
        #4;
        checks++; if (ramWE !== 2'b00) begin errors++; $display("FAIL rst_we: got %b expected 00", ramWE); end
        checks++; if (readBlock !== 1'b1) begin errors++; $display("FAIL rst_readblock: got %b expected 1", readBlock); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 512; c++) begin
            #4;
            checks++;
            if (ramWE !== 2'b01 || ramWA[8:0] !== 9'(c) || ramWValid[0] !== 1'b0 || ramWTag[9:0] !== 10'd0 || readBlock !== 1'b1) begin
                errors++;
                $display("FAIL init_sweep[%0d]: we=%b wa=%0d valid=%b tag=%0d blk=%b expected we=01 wa=%0d valid=0 tag=0 blk=1",
                         c, ramWE, ramWA[8:0], ramWValid[0], ramWTag[9:0], readBlock, c);
            end
            step();
        end
        set_req(2'b00, 0, 0);
        #4;
        checks++; if (readBlock !== 1'b0) begin errors++; $display("FAIL init_done_readblock: got %b expected 0", readBlock); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_done_busy: got %b expected 0", busy); end
        checks++; if (queueCount !== 3'd0) begin errors++; $display("FAIL init_no_queue: got %0d expected 0", queueCount); end
        checks++; if (dropCount !== 16'd0) begin errors++; $display("FAIL init_no_drop: got %0d expected 0", dropCount); end
        step();
    endtask

    task automatic test_parallel();
        set_req(2'b11, 4, 7);
        #4;
        checks++; if (ramWE !== 2'b11) begin errors++; $display("FAIL par_we: got %b expected 11", ramWE); end
        checks++; if (ramWA !== {9'd7, 9'd4}) begin errors++; $display("FAIL par_wa: got %0d/%0d expected 4/7", ramWA[8:0], ramWA[17:9]); end
        checks++; if (ramWTag !== {10'h107, 10'h104}) begin errors++; $display("FAIL par_tag: got %h expected %h", ramWTag, {10'h107, 10'h104}); end
        checks++; if (ramWValid !== 2'b11) begin errors++; $display("FAIL par_valid: got %b expected 11", ramWValid); end
        step();
        set_req(2'b00, 0, 0);
        #4;
        checks++; if (queueCount !== 3'd0) begin errors++; $display("FAIL par_qcount: got %0d expected 0", queueCount); end
        step();
    endtask

    task automatic test_conflict();
        set_req(2'b11, 4, 6);
        #4;
        checks++; if (ramWE !== 2'b01) begin errors++; $display("FAIL conf_we: got %b expected 01", ramWE); end
        checks++; if (ramWA[8:0] !== 9'd4) begin errors++; $display("FAIL conf_wa0: got %0d expected 4", ramWA[8:0]); end
        step();
        set_req(2'b00, 0, 0);
        #4;
        checks++; if (queueCount !== 3'd1) begin errors++; $display("FAIL conf_qcount: got %0d expected 1", queueCount); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL conf_busy: got %b expected 1", busy); end
        checks++; if (ramWE !== 2'b01 || ramWA[8:0] !== 9'd6 || ramWTag[9:0] !== 10'h106 || ramWValid[0] !== 1'b1) begin
            errors++; $display("FAIL conf_drain: we=%b wa=%0d tag=%h valid=%b expected we=01 wa=6 tag=106 valid=1", ramWE, ramWA[8:0], ramWTag[9:0], ramWValid[0]);
        end
        step();
        #4;
        checks++; if (queueCount !== 3'd0) begin errors++; $display("FAIL conf_empty: got %0d expected 0", queueCount); end
        checks++; if (ramWE !== 2'b00) begin errors++; $display("FAIL conf_idle_we: got %b expected 00", ramWE); end
        step();
    endtask

    task automatic test_full_queue();
        int fill0 [4] = '{2, 6, 10, 14};
        int fill1 [4] = '{4, 8, 12, 16};
        int port0 [4] = '{2, 4, 6, 8};
        for (int k = 0; k < 4; k++) begin
            set_req(2'b11, fill0[k], fill1[k]);
            #4;
            checks++; if (ramWE !== 2'b01 || ramWA[8:0] !== 9'(port0[k])) begin
                errors++; $display("FAIL fill[%0d]: we=%b wa0=%0d expected we=01 wa0=%0d", k, ramWE, ramWA[8:0], port0[k]);
            end
            step();
        end
        set_req(2'b11, 18, 20);
        #4;
        checks++; if (queueCount !== 3'd4) begin errors++; $display("FAIL full_qcount: got %0d expected 4", queueCount); end
        checks++; if (ramWE !== 2'b01 || ramWA[8:0] !== 9'd10) begin errors++; $display("FAIL full_head: we=%b wa0=%0d expected we=01 wa0=10", ramWE, ramWA[8:0]); end
        step();
        set_req(2'b11, 3, 5);
        #4;
        checks++; if (queueCount !== 3'd4) begin errors++; $display("FAIL full_after_qcount: got %0d expected 4", queueCount); end
        checks++; if (dropCount !== 16'd1) begin errors++; $display("FAIL full_drop: got %0d expected 1", dropCount); end
        checks++; if (ramWE !== 2'b11 || ramWA !== {9'd3, 9'd12}) begin
            errors++; $display("FAIL mixed_grant: we=%b wa=%0d/%0d expected we=11 wa=12/3", ramWE, ramWA[8:0], ramWA[17:9]);
        end
        step();
        set_req(2'b00, 0, 0);
        #4;
        checks++; if (queueCount !== 3'd4) begin errors++; $display("FAIL mixed_qcount: got %0d expected 4", queueCount); end
        checks++; if (ramWA[8:0] !== 9'd14 || ramWTag[9:0] !== 10'h10E) begin
            errors++; $display("FAIL mixed_head: wa0=%0d tag=%h expected wa0=14 tag=10e", ramWA[8:0], ramWTag[9:0]);
        end
        step();
    endtask

    task automatic test_flush();
        set_req(2'b01, 9, 0);
        flushReq = 1'b1;
        #4;
        checks++; if (queueCount !== 3'd3) begin errors++; $display("FAIL flush_qcount_before: got %0d expected 3", queueCount); end
        checks++; if (ramWE !== 2'b11 || ramWA !== {9'd9, 9'd16} || ramWValid !== 2'b11 || ramWTag[19:10] !== 10'h109) begin
            errors++; $display("FAIL flush_grants: we=%b wa=%0d/%0d valid=%b tag1=%h expected we=11 wa=16/9 valid=11 tag1=109",
                               ramWE, ramWA[8:0], ramWA[17:9], ramWValid, ramWTag[19:10]);
        end
        step();
        flushReq = 1'b0;
        set_req(2'b11, 21, 23);
        #4;
        checks++; if (queueCount !== 3'd0) begin errors++; $display("FAIL flush_cleared: got %0d expected 0", queueCount); end
        #1;
        for (int c = 0; c < 512; c++) begin
            if (c > 0) #4;
            checks++;
            if (ramWE !== 2'b01 || ramWA[8:0] !== 9'(c) || ramWValid[0] !== 1'b0 || readBlock !== 1'b1) begin
                errors++; $display("FAIL flush_sweep[%0d]: we=%b wa=%0d valid=%b blk=%b expected we=01 wa=%0d valid=0 blk=1",
                                   c, ramWE, ramWA[8:0], ramWValid[0], readBlock, c);
            end
            step();
        end
        set_req(2'b00, 0, 0);
        #4;
        checks++; if (readBlock !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_done: blk=%b busy=%b expected 0/0", readBlock, busy); end
        checks++; if (dropCount !== 16'd1) begin errors++; $display("FAIL flush_drop_kept: got %0d expected 1", dropCount); end
        checks++; if (queueCount !== 3'd0) begin errors++; $display("FAIL flush_done_qcount: got %0d expected 0", queueCount); end
        step();
    endtask

    task automatic test_reset_mid_sweep();
        flushReq = 1'b1;
        step();
        flushReq = 1'b0;
        for (int c = 0; c < 100; c++) step();
        #2;
        checks++; if (ramWE !== 2'b01 || ramWA[8:0] !== 9'd100) begin errors++; $display("FAIL mid_idx100: we=%b wa0=%0d expected we=01 wa0=100", ramWE, ramWA[8:0]); end
        rst = 1'b1;
        #2;
        checks++; if (ramWE !== 2'b00 || readBlock !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_rst_outputs: we=%b blk=%b busy=%b expected 00/1/1", ramWE, readBlock, busy);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 512; c++) begin
            #4;
            checks++;
            if (ramWE !== 2'b01 || ramWA[8:0] !== 9'(c) || readBlock !== 1'b1) begin
                errors++; $display("FAIL restart_sweep[%0d]: we=%b wa=%0d blk=%b expected we=01 wa=%0d blk=1", c, ramWE, ramWA[8:0], readBlock, c);
            end
            step();
        end
        #4;
        checks++; if (readBlock !== 1'b0) begin errors++; $display("FAIL restart_done: got %b expected 0", readBlock); end
        checks++; if (dropCount !== 16'd0) begin errors++; $display("FAIL restart_drop_cleared: got %0d expected 0", dropCount); end
        step();
    endtask

    initial begin
        rst = 1'b1;
        flushReq = 1'b0;
        reqValid = '0;
        reqIndex = '0;
        reqTag = '0;
        test_reset();
        test_parallel();
        test_conflict();
        test_full_queue();
        test_flush();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axbtb_write_scheduler.md
Name: axbtb_write_scheduler

Overview:
- Sequences all writes into the banked approximate-BCC buffer RAM.
- Shares that RAM's WRITE_NUM write ports between two sources: per-cycle branch-resolution update requests and a deferral queue for bank-conflicted updates.
- Owns the invalidation sweep after reset and on a flush command.
- Sits between the IntEx branch-result path and the buffer RAM; tells the fetch side when buffer hits must be ignored.

Parameters:
- ENTRY_NUM, 512, buffer entries; power of two.
- BANK_NUM, 2, RAM banks; power of two; bank = index mod BANK_NUM.
- WRITE_NUM, 2, update requesters and RAM write ports.
- QUEUE_SIZE, 4, deferral queue depth.
- TAG_WIDTH, 10, tag bits per entry.
- IDX_W, $clog2(ENTRY_NUM), derived index width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- flushReq  in  1  pulse: invalidate the whole buffer.
- reqValid  in  WRITE_NUM  update request valid, per requester.
- reqIndex  in  WRITE_NUM*IDX_W  update entry index.
- reqTag  in  WRITE_NUM*TAG_WIDTH  update tag.
- ramWE  out  WRITE_NUM  RAM write enable, per port.
- ramWA  out  WRITE_NUM*IDX_W  RAM write address.
- ramWTag  out  WRITE_NUM*TAG_WIDTH  RAM write tag.
- ramWValid  out  WRITE_NUM  valid bit written.
- readBlock  out  1  fetch must treat every buffer read as a miss.
- busy  out  1  state != RUN, or queue not empty.
- queueCount  out  $clog2(QUEUE_SIZE+1)  deferred entries held.
- dropCount  out  16  saturating count of dropped updates.

Behaviour:
- Write-port outputs are combinational from registered state plus this cycle's inputs.
- FSM states: INIT, RUN, FLUSH. Sweep index sweepIdx is IDX_W bits wide.
- While rst=1:
  - ramWE=0, readBlock=1, busy=1.
  - state<=INIT, sweepIdx<=0, queue emptied, dropCount<=0.
- rst asserted mid-sweep restarts the sweep at index 0.
- INIT and FLUSH sweep, one entry per cycle:
  - ramWE[0]=1, ramWA[0]=sweepIdx, ramWTag[0]=0, ramWValid[0]=0; all other ports off.
  - sweepIdx increments each cycle.
  - After the cycle with sweepIdx=ENTRY_NUM-1, go to RUN. A sweep lasts exactly ENTRY_NUM cycles.
  - readBlock=1 throughout the sweep.
  - Requests are discarded (not counted in dropCount). flushReq is ignored.
- RUN: readBlock=0 from the first RUN cycle.
  - Candidate order: queue head (if non-empty), then request 0..WRITE_NUM-1 (valid only).
  - Each candidate is granted if a port is free and its bank differs from every earlier grant this cycle.
  - Grants take ports 0,1,... in grant order, with ramWValid=1. Unused ports have ramWE=0.
  - At most one pop per cycle, and only if the head is granted. A blocked head blocks nothing else.
  - Ungranted valid requests are pushed in requester order while free = QUEUE_SIZE - queueCount + pop > 0.
  - Requests beyond free space are dropped; dropCount increases by the number dropped and saturates at 16'hFFFF.
  - Pop and push in the same cycle are legal; queueCount(next) = queueCount - pop + pushes.
  - Queue pointers wrap modulo QUEUE_SIZE.
  - Requests with identical index in one cycle map to the same bank, so the later one is deferred.
  - Cross-cycle write ordering to one index is not guaranteed. An update may be overwritten by an older queued one; this is acceptable because the buffer is approximate.
- flushReq in RUN:
  - That cycle's grants are still written.
  - Pushes are suppressed, and the queue is cleared at the clock edge; discarded entries are not counted as drops.
  - Next cycle: state=FLUSH, sweepIdx=0.

Test Plan:
- Reset with ENTRY_NUM=512: rst high 2 cycles, then low → ramWE[0]=1 with WA 0..511 on consecutive cycles, valid=0; readBlock=1 for 512 cycles; cycle 513 readBlock=0, busy=0.
- RUN, req0 idx 4, req1 idx 7 (banks 0,1) → both written same cycle on ports 0/1, queueCount stays 0.
- RUN, req0 idx 4, req1 idx 6 (both bank 0) → port0 writes 4, idx 6 queued (queueCount=1); next idle cycle port0 writes 6, queueCount=0.
- Queue full (4 entries, head bank blocked by nothing), both requests to bank 0 → head granted and popped, req0 and req1 blocked; free=1 → req0 pushed, req1 dropped; dropCount=1, queueCount=4.
- flushReq with queueCount=3 → grants of that cycle written, queue cleared, then 512-cycle sweep from index 0; dropCount unchanged.
- rst asserted at sweepIdx=100 during FLUSH → next sweep restarts at index 0 in INIT.
